// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: the canonical NOP, the IF/ID entry layout and
// the wrap-around pointer helper used by the in-order stage buffers.
package pipe_pkg;

  localparam int unsigned PIPE_XLEN = 32;
  localparam logic [31:0] RV_NOP    = 32'h00000013;

  typedef struct packed {
    logic [PIPE_XLEN-1:0] pc;
    logic [PIPE_XLEN-1:0] pc_4;
    logic [PIPE_XLEN-1:0] insn;
  } if_id_entry_t;

  // Advance a buffer pointer, wrapping after depth-1 (any depth 1..8).
  function automatic logic [2:0] ptr_inc(input logic [2:0] ptr, input int unsigned depth);
    if (32'(ptr) + 32'd1 >= depth) begin
      return 3'd0;
    end
    return ptr + 3'd1;
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
// i_load overrides counting and lets a value be preset.
module pipe_sat_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_en,
  input  logic        i_load,
  input  logic [31:0] i_load_val,
  output logic [31:0] o_count
);

  logic [31:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != 32'hFFFF_FFFF)) begin
      r_count <= r_count + 32'd1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/if_id_pipe_buffer.sv
// IF/ID boundary as a DEPTH-entry in-order valid/ready buffer of {pc, pc+4, insn}.
// Optional performance counters are enabled with the macro IF_ID_PERF_CNT_EN.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; valid never waits on ready, in_ready depends on buffer state only, and
// flush overrides both transfers in its cycle.
module if_id_pipe_buffer
  import pipe_pkg::*;
#(
  parameter int unsigned       XLEN     = 32,
  parameter int unsigned       DEPTH    = 2,
  parameter logic [XLEN-1:0]   NOP_INSN = XLEN'(RV_NOP)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_pc_4,
  input  logic [XLEN-1:0] in_insn,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc_4,
  output logic [XLEN-1:0] out_insn,
  output logic [3:0]      occupancy
`ifdef IF_ID_PERF_CNT_EN
  ,
  output logic [31:0]     perf_stall_cycles,
  output logic [31:0]     perf_bubble_cycles,
  output logic [31:0]     perf_flush_count
`endif
);

  localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  DEPTH_L = 4'(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_4;
    logic [XLEN-1:0] insn;
  } entry_t;

  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [3:0]       r_count;

  logic   w_push;
  logic   w_pop;
  logic   w_wr_en;
  entry_t w_head;

  assign in_ready  = (r_count < DEPTH_L);
  assign out_valid = (r_count != 4'd0);
  assign occupancy = r_count;

  assign w_push  = in_valid & in_ready;
  assign w_pop   = out_valid & out_ready;
  assign w_wr_en = w_push & ~flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= 4'd0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= 4'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= PTR_W'(ptr_inc(3'(r_wr_ptr), DEPTH));
      end
      if (w_pop) begin
        r_rd_ptr <= PTR_W'(ptr_inc(3'(r_rd_ptr), DEPTH));
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 4'd1;
        2'b01:   r_count <= r_count - 4'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage carries no reset: it is only ever observed through the
  // out_valid gate below, so stale or unknown contents cannot leak out.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= '{pc: in_pc, pc_4: in_pc_4, insn: in_insn};
    end
  end

  assign w_head   = r_mem[r_rd_ptr];
  assign out_pc   = out_valid ? w_head.pc   : '0;
  assign out_pc_4 = out_valid ? w_head.pc_4 : '0;
  assign out_insn = out_valid ? w_head.insn : NOP_INSN;

`ifdef IF_ID_PERF_CNT_EN
  logic w_stall_en;
  logic w_bubble_en;

  assign w_stall_en  = out_valid & ~out_ready;
  assign w_bubble_en = ~out_valid & ~flush;

  pipe_sat_counter u_stall_cnt (
    .clk        (clk),
    .rst_n      (reset_n),
    .i_en       (w_stall_en),
    .i_load     (1'b0),
    .i_load_val (32'd0),
    .o_count    (perf_stall_cycles)
  );

  pipe_sat_counter u_bubble_cnt (
    .clk        (clk),
    .rst_n      (reset_n),
    .i_en       (w_bubble_en),
    .i_load     (1'b0),
    .i_load_val (32'd0),
    .o_count    (perf_bubble_cycles)
  );

  pipe_sat_counter u_flush_cnt (
    .clk        (clk),
    .rst_n      (reset_n),
    .i_en       (flush),
    .i_load     (1'b0),
    .i_load_val (32'd0),
    .o_count    (perf_flush_count)
  );
`endif

endmodule

// File: tb/tb_if_id_pipe_buffer.sv
// Bench for if_id_pipe_buffer: a queue reference model of the in-order buffer,
// directed corner sequences followed by randomized traffic.
module tb_if_id_pipe_buffer;
  import pipe_pkg::*;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 3;
  localparam int unsigned W     = 3 * XLEN;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset_n   = 1'b1;
  logic            flush     = 1'b0;
  logic            in_valid  = 1'b0;
  logic            in_ready;
  logic [XLEN-1:0] in_pc     = '0;
  logic [XLEN-1:0] in_pc_4   = '0;
  logic [XLEN-1:0] in_insn   = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_pc_4;
  logic [XLEN-1:0] out_insn;
  logic [3:0]      occupancy;
`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_bubble_cycles;
  logic [31:0] perf_flush_count;
`endif

  if_id_pipe_buffer #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_pc_4   (in_pc_4),
    .in_insn   (in_insn),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_pc_4  (out_pc_4),
    .out_insn  (out_insn),
    .occupancy (occupancy)
`ifdef IF_ID_PERF_CNT_EN
    ,
    .perf_stall_cycles  (perf_stall_cycles),
    .perf_bubble_cycles (perf_bubble_cycles),
    .perf_flush_count   (perf_flush_count)
`endif
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_err    = 0;
  bit mon_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

`ifdef IF_ID_PERF_CNT_EN
  int unsigned exp_stall  = 0;
  int unsigned exp_bubble = 0;
  int unsigned exp_flush  = 0;
`endif

  // Monitor: mid-cycle, compare visible state against the model and retire
  // the head entry when the coming edge will transfer it to decode.
  int           mon_sz;
  logic [W-1:0] mon_head;
  always @(negedge clk) begin
    if (mon_en && reset_n) begin
      mon_sz = exp_q.size();
      chk("out_valid", 32'(out_valid), 32'(mon_sz != 0));
      chk("occupancy", 32'(occupancy), 32'(mon_sz));
      chk("in_ready",  32'(in_ready),  32'(mon_sz < int'(DEPTH)));
      if (mon_sz != 0) begin
        mon_head = exp_q[0];
        chk("out_pc",   out_pc,   mon_head[W-1 -: XLEN]);
        chk("out_pc_4", out_pc_4, mon_head[2*XLEN-1 -: XLEN]);
        chk("out_insn", out_insn, mon_head[XLEN-1:0]);
        if (out_ready && !flush) void'(exp_q.pop_front());
      end else begin
        chk("idle_pc",   out_pc,   32'd0);
        chk("idle_pc_4", out_pc_4, 32'd0);
        chk("idle_insn", out_insn, RV_NOP);
      end
`ifdef IF_ID_PERF_CNT_EN
      chk("perf_stall",  perf_stall_cycles,  exp_stall);
      chk("perf_bubble", perf_bubble_cycles, exp_bubble);
      chk("perf_flush",  perf_flush_count,   exp_flush);
      if ((mon_sz != 0) && !out_ready) exp_stall++;
      if ((mon_sz == 0) && !flush)     exp_bubble++;
      if (flush)                       exp_flush++;
`endif
    end
  end

  // ---------------- driver ----------------
  // Called just after a rising edge; returns just after the next one.
  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] insn,
                       input logic rdy, input logic fl);
    logic acc;
    in_valid  = v;
    out_ready = rdy;
    flush     = fl;
    if (v) begin
      in_pc   = pc;
      in_pc_4 = pc + 32'd4;
      in_insn = insn;
    end else begin
      in_pc   = $urandom;
      in_pc_4 = $urandom;
      in_insn = $urandom;
    end
    acc = v && !fl && (exp_q.size() < int'(DEPTH));
    @(posedge clk);
    #2;
    if (fl) exp_q.delete();
    else if (acc) exp_q.push_back({pc, pc + 32'd4, insn});
  endtask

`ifdef IF_ID_PERF_CNT_EN
  logic        sat_en   = 1'b0;
  logic        sat_load = 1'b0;
  logic [31:0] sat_val  = '0;
  logic [31:0] sat_count;
  pipe_sat_counter u_sat (
    .clk        (clk),
    .rst_n      (reset_n),
    .i_en       (sat_en),
    .i_load     (sat_load),
    .i_load_val (sat_val),
    .o_count    (sat_count)
  );
`endif

  // ---------------- main sequence ----------------
  initial begin
    #1 reset_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_pc",    out_pc,         32'd0);
    chk("rst_out_insn",  out_insn,       RV_NOP);
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // fill, refuse when full while popping, then flush with a push pending
    drive(1'b1, 32'h100, 32'h00500093, 1'b0, 1'b0);
    drive(1'b1, 32'h104, 32'h00a00113, 1'b0, 1'b0);
    drive(1'b1, 32'h108, 32'h002081b3, 1'b0, 1'b0);
    drive(1'b1, 32'h10c, 32'h40308233, 1'b1, 1'b0);
    drive(1'b0, 32'h0,   32'h0,        1'b0, 1'b0);
    drive(1'b1, 32'h110, 32'h00000073, 1'b0, 1'b0);
    drive(1'b1, 32'h200, 32'h00100093, 1'b0, 1'b1);
    drive(1'b0, 32'h0,   32'h0,        1'b0, 1'b0);
    drive(1'b0, 32'h0,   32'h0,        1'b0, 1'b1);

    // steady push/pop pairs, pointers wrap repeatedly at depth 3
    drive(1'b1, 32'h300, 32'h00000093, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)
      drive(1'b1, 32'h304 + 32'(4 * i), 32'h00000113 + 32'(i << 20), 1'b1, 1'b0);

    // five stalled cycles then a flush
    repeat (5) drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 3) != 0), {$urandom_range(0, 32'h3fff_ffff), 2'b00}, $urandom,
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0));
    end

    // bounded drain
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    // asynchronous reset with two entries held
    drive(1'b1, 32'h400, 32'h00500093, 1'b0, 1'b0);
    drive(1'b1, 32'h404, 32'h00600093, 1'b0, 1'b0);
    drive(1'b0, 32'h0,   32'h0,        1'b0, 1'b0);
    in_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    chk("async_out_valid", 32'(out_valid), 32'd0);
    chk("async_occupancy", 32'(occupancy), 32'd0);
    chk("async_in_ready",  32'(in_ready),  32'd1);
    chk("async_out_pc",    out_pc,         32'd0);
    chk("async_out_pc_4",  out_pc_4,       32'd0);
    chk("async_out_insn",  out_insn,       RV_NOP);
`ifdef IF_ID_PERF_CNT_EN
    chk("async_perf_stall", perf_stall_cycles, 32'd0);
    exp_stall  = 0;
    exp_bubble = 0;
    exp_flush  = 0;
`endif
    exp_q.delete();
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    drive(1'b1, 32'h500, 32'h00700093, 1'b1, 1'b0);
    drive(1'b0, 32'h0,   32'h0,        1'b1, 1'b0);
    drive(1'b0, 32'h0,   32'h0,        1'b1, 1'b0);

`ifdef IF_ID_PERF_CNT_EN
    sat_val  = 32'hFFFF_FFFF;
    sat_load = 1'b1;
    @(posedge clk);
    #2;
    sat_load = 1'b0;
    sat_en   = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("sat_hold", sat_count, 32'hFFFF_FFFF);
    sat_en = 1'b0;
`endif

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
